// File: rtl/fsm_stream_arbiter_pkg.sv
// Shared types for the two-requester serial stream arbiter.
// Holds core/controller state encodings, widths and the round-robin pick.
package fsm_stream_arbiter_pkg;

  localparam int LEN_W = 4;
  localparam int N_REQ = 2;

  typedef enum logic [1:0] {
    ST_A = 2'b00,
    ST_B = 2'b01,
    ST_C = 2'b11
  } core_state_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CLEAR = 2'b01,
    RUN   = 2'b10,
    DONE  = 2'b11
  } ctrl_state_e;

  // Contention goes to the requester that did not own the last burst.
  function automatic logic rr_pick(
    input logic [N_REQ-1:0] req,
    input logic             last
  );
    if (&req) return ~last;
    return req[1];
  endfunction

endpackage

// File: rtl/fsm_stream_arbiter_core.sv
// Three-state A/B/C Mealy core shared between the two requesters.
// Holds when disabled; synchronous clear wins over enable.
module abc_mealy_core
  import fsm_stream_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic       x,
  output logic [1:0] state,
  output logic       y,
  output logic       z
);

  logic [1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    y       = 1'b0;
    z       = 1'b0;
    case (state_q)
      ST_A: begin
        state_d = x ? ST_C : ST_B;
        y       = x;
        z       = 1'b1;
      end
      ST_B: begin
        state_d = x ? ST_C : ST_B;
        y       = 1'b1;
      end
      ST_C: begin
        state_d = x ? ST_C : ST_A;
      end
      // 2'b10 steps like A but drives 00.
      default: begin
        state_d = x ? ST_C : ST_B;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_A;
    end else if (clr) begin
      state_q <= ST_A;
    end else if (en) begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/fsm_stream_arbiter.sv
// Round-robin burst arbiter feeding one requester's serial bits
// into the shared A/B/C Mealy core for a latched burst length.
module fsm_stream_arbiter
  import fsm_stream_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  input  logic [N_REQ-1:0] x_in,
  output logic [N_REQ-1:0] gnt,
  output logic             out_valid,
  output logic             out_id,
  output logic             y,
  output logic             z,
  output logic [1:0]       core_state,
  output logic             done,
  output logic             abort
);

  ctrl_state_e      st_q;
  logic             id_q;
  logic             last_q;
  logic             abort_q;
  logic [LEN_W-1:0] cnt_q;

  logic run, live, win;
  logic core_y, core_z;

  assign run  = (st_q == RUN);
  assign live = run & req[id_q];
  assign win  = rr_pick(req, last_q);

  abc_mealy_core u_core (
    .clk   (clk),
    .rst   (rst),
    .en    (live),
    .clr   (st_q == CLEAR),
    .x     (x_in[id_q]),
    .state (core_state),
    .y     (core_y),
    .z     (core_z)
  );

  always_comb begin
    gnt       = '0;
    gnt[id_q] = run;
  end

  assign out_valid = live;
  assign out_id    = id_q;
  assign y         = live & core_y;
  assign z         = live & core_z;
  assign done      = (st_q == DONE);
  assign abort     = done & abort_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q    <= IDLE;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
      abort_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (st_q)
        IDLE: begin
          if (|req) begin
            id_q    <= win;
            cnt_q   <= win ? len1 : len0;
            abort_q <= 1'b0;
            st_q    <= CLEAR;
          end
        end
        CLEAR: begin
          st_q <= (cnt_q == '0) ? DONE : RUN;
        end
        RUN: begin
          if (!req[id_q]) begin
            abort_q <= 1'b1;
            st_q    <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == 4'd1) st_q <= DONE;
          end
        end
        DONE: begin
          last_q <= id_q;
          st_q   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_stream_arbiter.sv
// Scoreboard bench: bursts are predicted from the A/B/C rules and
// the round-robin policy, then matched against observed beats/ends.
module tb_fsm_stream_arbiter;

  typedef struct {
    logic       id;
    logic [1:0] yz;
    logic [1:0] st;
  } beat_t;

  typedef struct {
    logic       id;
    logic       ab;
    logic [1:0] st;
  } end_t;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic [3:0] len0, len1;
  logic [1:0] x_in;
  logic [1:0] gnt;
  logic       out_valid, out_id, y, z;
  logic [1:0] core_state;
  logic       done, abort;

  beat_t bq[$];
  end_t  eq[$];
  beat_t mb;
  end_t  me;

  int checks   = 0;
  int failures = 0;
  logic last_m;

  fsm_stream_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .len0       (len0),
    .len1       (len1),
    .x_in       (x_in),
    .gnt        (gnt),
    .out_valid  (out_valid),
    .out_id     (out_id),
    .y          (y),
    .z          (z),
    .core_state (core_state),
    .done       (done),
    .abort      (abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference core: states 0=A 1=B 2=C.
  function automatic int nxt_f(input int s, input logic x);
    case (s)
      0:       return x ? 2 : 1;
      1:       return x ? 2 : 1;
      default: return x ? 2 : 0;
    endcase
  endfunction

  function automatic logic [1:0] yz_f(input int s, input logic x);
    case (s)
      0:       return x ? 2'b11 : 2'b01;
      1:       return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] code_f(input int s);
    case (s)
      0:       return 2'b00;
      1:       return 2'b01;
      default: return 2'b11;
    endcase
  endfunction

  always @(negedge clk) begin
    chk("gnt_onehot", int'($countones(gnt) <= 1), 1);
    if (out_valid) begin
      chk("beat_avail", int'(bq.size() != 0), 1);
      if (bq.size() != 0) begin
        mb = bq.pop_front();
        chk("out_id", int'(out_id), int'(mb.id));
        chk("gnt", int'(gnt), 1 << mb.id);
        chk("yz", int'({y, z}), int'(mb.yz));
        chk("core_state", int'(core_state), int'(mb.st));
      end
    end else begin
      chk("yz_masked", int'({y, z}), 0);
    end
    if (done) begin
      chk("end_avail", int'(eq.size() != 0), 1);
      if (eq.size() != 0) begin
        me = eq.pop_front();
        chk("done_id", int'(out_id), int'(me.id));
        chk("abort", int'(abort), int'(me.ab));
        chk("done_gnt", int'(gnt), 0);
        chk("hold_state", int'(core_state), int'(me.st));
      end
    end else begin
      chk("abort_qual", int'(abort), 0);
    end
  end

  task automatic burst(
    input logic [1:0]  p,
    input logic [3:0]  l0,
    input logic [3:0]  l1,
    input int          drop_k,
    input int          rst_at,
    input bit          gap,
    input logic [15:0] xs
  );
    logic w;
    int   len, lim, s;
    bit   ab, hit;
    w   = (p == 2'b11) ? ~last_m : p[1];
    len = w ? int'(l1) : int'(l0);
    ab  = (drop_k >= 1) && (drop_k <= len);
    lim = ab ? drop_k - 1 : len;
    if (rst_at >= 0 && rst_at < lim) lim = rst_at;
    s = 0;
    for (int i = 0; i < lim; i++) begin
      bq.push_back('{w, yz_f(s, xs[i]), code_f(s)});
      s = nxt_f(s, xs[i]);
    end
    if (rst_at < 0) begin
      eq.push_back('{w, ab, code_f(s)});
      last_m = w;
    end
    req  = p;
    len0 = l0;
    len1 = l1;
    x_in = 2'($urandom);
    @(posedge clk); #1;
    len0 = 4'($urandom);
    len1 = 4'($urandom);
    x_in = 2'($urandom);
    @(posedge clk); #1;
    hit = 1'b0;
    for (int i = 0; i < len; i++) begin
      x_in    = 2'($urandom);
      x_in[w] = xs[i];
      if (i + 1 == drop_k) req[w] = 1'b0;
      if (i == rst_at) begin
        #2 rst = 1'b0;
        #1;
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_core", int'(core_state), 0);
        chk("rst_done", int'(done), 0);
        hit = 1'b1;
        break;
      end
      @(posedge clk); #1;
      if (i + 1 == drop_k) break;
    end
    if (hit) begin
      last_m = 1'b1;
      req    = 2'b00;
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
      @(posedge clk); #1;
    end else begin
      if (gap) req = 2'b00;
      x_in = 2'($urandom);
      @(posedge clk); #1;
      if (gap) repeat ($urandom_range(0, 2)) @(posedge clk);
      if (gap) #0;
    end
  endtask

  initial begin
    rst    = 1'b0;
    req    = 2'b00;
    len0   = 4'd0;
    len1   = 4'd0;
    x_in   = 2'b00;
    last_m = 1'b1;
    #2;
    chk("reset_gnt", int'(gnt), 0);
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_core", int'(core_state), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_abort", int'(abort), 0);
    chk("reset_yz", int'({y, z}), 0);
    chk("reset_id", int'(out_id), 0);
    #21 rst = 1'b1;
    @(posedge clk); #1;

    burst(2'b11, 4'd2, 4'd3, 0, -1, 1'b0, 16'($urandom));
    burst(2'b11, 4'd2, 4'd3, 0, -1, 1'b1, 16'($urandom));
    burst(2'b01, 4'd3, 4'd7, 0, -1, 1'b1, 16'h0003);
    burst(2'b10, 4'd6, 4'd0, 0, -1, 1'b1, 16'($urandom));
    burst(2'b01, 4'd5, 4'd2, 3, -1, 1'b1, 16'($urandom));
    burst(2'b01, 4'd4, 4'd9, 0, -1, 1'b1, 16'h0004);
    burst(2'b01, 4'd15, 4'd1, 0, -1, 1'b0, 16'($urandom));

    repeat (150) begin
      logic [1:0] p;
      int         dk;
      p  = 2'($urandom_range(1, 3));
      dk = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 16) : 0;
      burst(p, 4'($urandom), 4'($urandom), dk, -1,
            1'($urandom_range(0, 1)), 16'($urandom));
    end

    burst(2'b01, 4'd8, 4'd0, 0, 3, 1'b1, 16'($urandom));
    burst(2'b11, 4'd2, 4'd2, 0, -1, 1'b1, 16'($urandom));

    repeat (5) @(posedge clk);
    #1;
    chk("beats_left", bq.size(), 0);
    chk("ends_left", eq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
